// File: rtl/npc_idu_stage.sv
// Instruction-decode stage: decodes fetched {pc, inst} into a registered
// bundle for execute, with one skid entry behind the output register so
// that in_ready never depends combinationally on out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a producer holding valid=1 keeps its payload stable until ready.
module npc_idu_stage #(
    parameter int          NREG     = 16,
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [2:0]  out_funct3,
    output logic        out_alt,
    output logic [3:0]  out_cls,
    output logic        out_rf_wen,
    output logic        out_ebreak,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        alt;
        logic [3:0]  cls;
        logic        rf_wen;
        logic        ebreak;
        logic        illegal;
    } bundle_t;

    localparam logic [5:0] NREG_L = 6'(NREG);

    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;

    logic [3:0]  cls_raw;
    logic [31:0] imm_raw;
    logic        use_rd, use_rs1, use_rs2;
    logic        wen_cls;
    logic        reg_bad, sys_bad;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        cls_raw = 4'd15;
        imm_raw = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wen_cls = 1'b0;
        unique case (in_inst[6:0])
            7'b0110111: begin cls_raw = 4'd0;  use_rd = 1'b1; wen_cls = 1'b1;
                              imm_raw = {in_inst[31:12], 12'b0}; end
            7'b0010111: begin cls_raw = 4'd1;  use_rd = 1'b1; wen_cls = 1'b1;
                              imm_raw = {in_inst[31:12], 12'b0}; end
            7'b1101111: begin cls_raw = 4'd2;  use_rd = 1'b1; wen_cls = 1'b1;
                              imm_raw = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                         in_inst[20], in_inst[30:21], 1'b0}; end
            7'b1100111: begin cls_raw = 4'd3;  use_rd = 1'b1; use_rs1 = 1'b1; wen_cls = 1'b1;
                              imm_raw = {{20{in_inst[31]}}, in_inst[31:20]}; end
            7'b1100011: begin cls_raw = 4'd4;  use_rs1 = 1'b1; use_rs2 = 1'b1;
                              imm_raw = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                         in_inst[30:25], in_inst[11:8], 1'b0}; end
            7'b0000011: begin cls_raw = 4'd5;  use_rd = 1'b1; use_rs1 = 1'b1; wen_cls = 1'b1;
                              imm_raw = {{20{in_inst[31]}}, in_inst[31:20]}; end
            7'b0100011: begin cls_raw = 4'd6;  use_rs1 = 1'b1; use_rs2 = 1'b1;
                              imm_raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}; end
            7'b0010011: begin cls_raw = 4'd7;  use_rd = 1'b1; use_rs1 = 1'b1; wen_cls = 1'b1;
                              imm_raw = {{20{in_inst[31]}}, in_inst[31:20]}; end
            7'b0110011: begin cls_raw = 4'd8;  use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                              wen_cls = 1'b1; end
            7'b1110011: begin cls_raw = 4'd9;
                              imm_raw = {{20{in_inst[31]}}, in_inst[31:20]};
                              // CSR forms name rd; register forms (funct3[2]=0) also read rs1
                              use_rd  = (in_inst[14:12] != 3'b000);
                              use_rs1 = (in_inst[14:12] != 3'b000) && !in_inst[14]; end
            7'b0001111: begin cls_raw = 4'd10; end
            default:    begin cls_raw = 4'd15; end
        endcase

        reg_bad = (use_rd  && ({1'b0, in_inst[11:7]}  >= NREG_L)) ||
                  (use_rs1 && ({1'b0, in_inst[19:15]} >= NREG_L)) ||
                  (use_rs2 && ({1'b0, in_inst[24:20]} >= NREG_L));
        sys_bad = (cls_raw == 4'd9) && (in_inst[14:12] == 3'b000) &&
                  (in_inst != 32'h00000073) && (in_inst != 32'h00100073);

        dec         = '0;
        dec.pc      = in_pc;
        dec.inst    = in_inst;
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.funct3  = in_inst[14:12];
        dec.illegal = (in_inst[1:0] != 2'b11) || (cls_raw == 4'd15) || reg_bad || sys_bad;
        if (dec.illegal) begin
            dec.cls = 4'd15;
        end else begin
            dec.cls    = cls_raw;
            dec.imm    = imm_raw;
            dec.rf_wen = wen_cls && (in_inst[11:7] != 5'd0);
            dec.alt    = ((cls_raw == 4'd8) ||
                          ((cls_raw == 4'd7) && (in_inst[14:12] == 3'b101))) && in_inst[30];
            dec.ebreak = (in_inst == 32'h00100073);
        end
    end

    logic out_load;
    logic in_fire;
    assign out_load = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    // Output register plus skid entry; the skid always drains before new input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_q.pc     <= RESET_PC;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_inst    = out_q.inst;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = out_q.imm;
    assign out_funct3  = out_q.funct3;
    assign out_alt     = out_q.alt;
    assign out_cls     = out_q.cls;
    assign out_rf_wen  = out_q.rf_wen;
    assign out_ebreak  = out_q.ebreak;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_npc_idu_stage.sv
// Directed bench for npc_idu_stage: reset, decode vectors, backpressure
// through the skid entry, and flush.
module tb_npc_idu_stage;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_funct3;
    logic        out_alt;
    logic [3:0]  out_cls;
    logic        out_rf_wen;
    logic        out_ebreak;
    logic        out_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    npc_idu_stage #(.NREG(16), .RESET_PC(32'h80000000)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_funct3(out_funct3), .out_alt(out_alt), .out_cls(out_cls),
        .out_rf_wen(out_rf_wen), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    // Expect an illegal bundle at the output.
    task automatic chk_illegal(input string tag);
        chk({tag, " valid"},   32'(out_valid),   32'd1);
        chk({tag, " illegal"}, 32'(out_illegal), 32'd1);
        chk({tag, " cls"},     32'(out_cls),     32'd15);
        chk({tag, " rf_wen"},  32'(out_rf_wen),  32'd0);
        chk({tag, " imm"},     out_imm,          32'd0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(32'h80000000, 32'h00100073);

        // Reset held two cycles with in_valid asserted.
        tick(); tick();
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst ready", 32'(in_ready),  32'd1);
        chk("rst pc",    out_pc,         32'h80000000);
        chk("rst cls",   32'(out_cls),   32'd0);
        chk("rst inst",  out_inst,       32'd0);

        // ebreak right after reset release.
        rstn = 1'b1;
        tick();
        chk("ebreak valid",  32'(out_valid),   32'd1);
        chk("ebreak flag",   32'(out_ebreak),  32'd1);
        chk("ebreak cls",    32'(out_cls),     32'd9);
        chk("ebreak rf_wen", 32'(out_rf_wen),  32'd0);
        chk("ebreak ill",    32'(out_illegal), 32'd0);
        chk("ebreak pc",     out_pc,           32'h80000000);

        // addi x1,x0,-1
        drive(32'h80000004, 32'hFFF00093); tick();
        chk("addi imm",    out_imm,         32'hFFFFFFFF);
        chk("addi rd",     32'(out_rd),     32'd1);
        chk("addi cls",    32'(out_cls),    32'd7);
        chk("addi rf_wen", 32'(out_rf_wen), 32'd1);
        chk("addi pc",     out_pc,          32'h80000004);

        // beq x0,x0,-4
        drive(32'h80000008, 32'hFE000EE3); tick();
        chk("beq imm",    out_imm,         32'hFFFFFFFC);
        chk("beq cls",    32'(out_cls),    32'd4);
        chk("beq rf_wen", 32'(out_rf_wen), 32'd0);

        // lui x1,0x12345
        drive(32'h8000000C, 32'h123450B7); tick();
        chk("lui imm",    out_imm,         32'h12345000);
        chk("lui cls",    32'(out_cls),    32'd0);
        chk("lui rf_wen", 32'(out_rf_wen), 32'd1);

        // nop: rd=x0
        drive(32'h80000010, 32'h00000013); tick();
        chk("nop rf_wen", 32'(out_rf_wen),  32'd0);
        chk("nop ill",    32'(out_illegal), 32'd0);
        chk("nop cls",    32'(out_cls),     32'd7);

        // srai x1,x1,1: alt set, funct3=5, imm=0x401
        drive(32'h80000014, 32'h4010D093); tick();
        chk("srai alt",    32'(out_alt),    32'd1);
        chk("srai funct3", 32'(out_funct3), 32'd5);
        chk("srai imm",    out_imm,         32'h00000401);

        // sub x0,x1,x2: OP with alt, no write to x0, no immediate
        drive(32'h80000018, 32'h40208033); tick();
        chk("sub alt",    32'(out_alt),    32'd1);
        chk("sub cls",    32'(out_cls),    32'd8);
        chk("sub rf_wen", 32'(out_rf_wen), 32'd0);
        chk("sub imm",    out_imm,         32'd0);
        chk("sub rs2",    32'(out_rs2),    32'd2);

        // Illegal encodings.
        drive(32'h8000001C, 32'h00000000); tick(); chk_illegal("zero");
        drive(32'h80000020, 32'h0000007F); tick(); chk_illegal("op7f");
        // addi x1,x16,0: rs1 outside RV32E
        drive(32'h80000024, 32'h00080093); tick(); chk_illegal("rs1x16");
        chk("rs1x16 rs1", 32'(out_rs1), 32'd16);
        // addi x16,x0,0: rd outside RV32E
        drive(32'h80000028, 32'h00000813); tick(); chk_illegal("rdx16");
        // SYSTEM funct3=0 that is neither ecall nor ebreak
        drive(32'h8000002C, 32'h00200073); tick(); chk_illegal("sys0");
        // ecall is legal
        drive(32'h80000030, 32'h00000073); tick();
        chk("ecall ill",    32'(out_illegal), 32'd0);
        chk("ecall cls",    32'(out_cls),     32'd9);
        chk("ecall ebreak", 32'(out_ebreak),  32'd0);

        in_valid = 1'b0; tick();
        chk("idle valid", 32'(out_valid), 32'd0);

        // Backpressure: I0..I3 = addi xK,x0,K at pc 0x100..0x10C.
        drive(32'h100, 32'h00100093); tick();
        chk("bp0 pc",    out_pc,         32'h100);
        chk("bp0 ready", 32'(in_ready),  32'd1);
        out_ready = 1'b0;
        drive(32'h104, 32'h00200113); tick();          // I1 goes to skid
        chk("bp1 pc",    out_pc,         32'h100);
        chk("bp1 ready", 32'(in_ready),  32'd0);
        drive(32'h108, 32'h00300193); tick();          // I2 held by producer
        chk("bp2 pc",    out_pc,         32'h100);
        chk("bp2 valid", 32'(out_valid), 32'd1);
        chk("bp2 ready", 32'(in_ready),  32'd0);
        tick();
        chk("bp3 pc",    out_pc,         32'h100);
        chk("bp3 imm",   out_imm,        32'd1);
        out_ready = 1'b1; tick();                      // I0 taken, skid drains
        chk("bp4 pc",    out_pc,         32'h104);
        chk("bp4 rd",    32'(out_rd),    32'd2);
        chk("bp4 ready", 32'(in_ready),  32'd1);
        tick();                                        // I1 taken, I2 enters
        chk("bp5 pc",    out_pc,         32'h108);
        drive(32'h10C, 32'h00400213); tick();
        chk("bp6 pc",    out_pc,         32'h10C);
        chk("bp6 imm",   out_imm,        32'd4);
        in_valid = 1'b0; tick();
        chk("bp7 valid", 32'(out_valid), 32'd0);

        // Flush with output and skid both occupied.
        out_ready = 1'b0;
        drive(32'h200, 32'h00500293); tick();
        drive(32'h204, 32'h00600313); tick();
        chk("fl skid ready", 32'(in_ready),  32'd0);
        chk("fl out pc",     out_pc,         32'h200);
        flush = 1'b1;
        drive(32'h208, 32'h00700393); tick();
        chk("fl1 valid", 32'(out_valid), 32'd0);
        chk("fl1 ready", 32'(in_ready),  32'd1);
        // Flush with a concurrent input fire: the input is discarded.
        drive(32'h20C, 32'h00800413); tick();
        chk("fl2 valid", 32'(out_valid), 32'd0);
        chk("fl2 ready", 32'(in_ready),  32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("fl3 valid", 32'(out_valid), 32'd0);
        drive(32'h300, 32'h00900493); tick();
        chk("post pc",    out_pc,         32'h300);
        chk("post rd",    32'(out_rd),    32'd9);
        chk("post valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; tick();
        chk("post idle",  32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
